xm_fetch_unit: RTL and testbench

- Instruction fetch stage of the XM multi-cycle core. It sits directly upstream of the instruction decoder.
- Owns the PC, runs a req/ack read transaction to instruction memory, and latches the returned word into the instruction register.
- Presents the word with its address to the decoder/control unit under a valid/ready handshake.
- Accepts branch/trap redirects from the control unit. These may arrive at any time, including while a memory transaction is outstanding.

---
 rtl/xm_pkg.sv | 15 +
 rtl/xm_pc_reg.sv | 50 +++++
 rtl/xm_fetch_unit.sv | 155 +++++++++++++++
 tb/tb_xm_fetch_unit.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xm_pkg.sv
// Shared definitions for the XM core fetch path: datapath width, reset PC and
// the fetch state encoding (also exported to the control unit for debug).
package xm_pkg;

  localparam int unsigned        XM_WORD     = 16;
  localparam logic [XM_WORD-1:0] XM_RESET_PC = 16'h0000;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2,
    FAULT   = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/xm_pc_reg.sv
// PC and pending-redirect-target register pair with load, increment-by-2 and
// an alignment flag on the value presented for loading.
module xm_pc_reg #(
  parameter int unsigned     WORD     = 16,
  parameter logic [WORD-1:0] RESET_PC = '0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            pc_load_i,
  input  logic [WORD-1:0] pc_val_i,
  input  logic            pc_inc_i,
  input  logic            pend_load_i,
  input  logic [WORD-1:0] pend_val_i,
  output logic [WORD-1:0] pc_o,
  output logic [WORD-1:0] pend_o,
  output logic            pc_val_odd_o
);

  logic [WORD-1:0] pc_q, pc_d;
  logic [WORD-1:0] pend_q, pend_d;

  always_comb begin
    pc_d   = pc_q;
    pend_d = pend_q;
    // A load always wins over the sequential increment.
    if (pc_load_i) begin
      pc_d = pc_val_i;
    end else if (pc_inc_i) begin
      pc_d = pc_q + WORD'(2);
    end
    if (pend_load_i) begin
      pend_d = pend_val_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q   <= RESET_PC;
      pend_q <= '0;
    end else begin
      pc_q   <= pc_d;
      pend_q <= pend_d;
    end
  end

  assign pc_o         = pc_q;
  assign pend_o       = pend_q;
  assign pc_val_odd_o = pc_val_i[0];

endmodule

// File: rtl/xm_fetch_unit.sv
// XM instruction fetch stage: owns the PC, runs req/ack reads to instruction
// memory and hands the fetched word to the decoder under valid/ready.
module xm_fetch_unit
  import xm_pkg::*;
#(
  parameter int unsigned     WORD     = XM_WORD,
  parameter logic [WORD-1:0] RESET_PC = XM_RESET_PC
) (
  input  logic            clk_i,
  input  logic            rst_i,
  output logic            memReq_o,
  output logic [WORD-1:0] memAdr_o,
  input  logic            memAck_i,
  input  logic [WORD-1:0] memData_i,
  output logic [WORD-1:0] inst_o,
  output logic [WORD-1:0] instPc_o,
  output logic [WORD-1:0] pcNext_o,
  output logic            instValid_o,
  input  logic            instReady_i,
  input  logic            redirect_i,
  input  logic [WORD-1:0] redirectPc_i,
  output logic            alignFault_o
);

  fetch_state_e    state_q, state_d;
  logic            started_q;
  logic [WORD-1:0] inst_q, inst_d;
  logic [WORD-1:0] inst_pc_q, inst_pc_d;
  logic            valid_q, valid_d;
  logic            fault_q, fault_d;

  logic [WORD-1:0] pc;
  logic [WORD-1:0] pend;
  logic [WORD-1:0] pc_val;
  logic            pc_val_odd;
  logic            pc_load;
  logic            pc_inc;
  logic            pend_load;
  logic            take_target;
  logic            mem_ack;

  xm_pc_reg #(
    .WORD     (WORD),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .pc_load_i    (pc_load),
    .pc_val_i     (pc_val),
    .pc_inc_i     (pc_inc),
    .pend_load_i  (pend_load),
    .pend_val_i   (redirectPc_i),
    .pc_o         (pc),
    .pend_o       (pend),
    .pc_val_odd_o (pc_val_odd)
  );

  // started_q holds the request off for the first cycle after reset.
  assign memReq_o = started_q && ((state_q == FETCH) || (state_q == DISCARD));
  assign memAdr_o = pc;
  assign mem_ack  = memAck_i && memReq_o;

  // A completing discard with no fresh redirect resumes at the parked target.
  assign pc_val = ((state_q == DISCARD) && !redirect_i) ? pend : redirectPc_i;

  always_comb begin
    state_d     = state_q;
    inst_d      = inst_q;
    inst_pc_d   = inst_pc_q;
    valid_d     = valid_q;
    fault_d     = fault_q;
    pc_inc      = 1'b0;
    pend_load   = 1'b0;
    take_target = 1'b0;

    case (state_q)
      FETCH: begin
        if (redirect_i) begin
          if (mem_ack || !memReq_o) begin
            take_target = 1'b1;
          end else begin
            pend_load = 1'b1;
            state_d   = DISCARD;
          end
        end else if (mem_ack) begin
          inst_d    = memData_i;
          inst_pc_d = pc;
          valid_d   = 1'b1;
          pc_inc    = 1'b1;
          state_d   = HOLD;
        end
      end
      HOLD: begin
        if (redirect_i) begin
          valid_d     = 1'b0;
          take_target = 1'b1;
        end else if (instReady_i) begin
          valid_d = 1'b0;
          state_d = FETCH;
        end
      end
      DISCARD: begin
        if (mem_ack) begin
          take_target = 1'b1;
        end else if (redirect_i) begin
          pend_load = 1'b1;
        end
      end
      FAULT: begin
        if (redirect_i) begin
          take_target = 1'b1;
        end
      end
      default: state_d = FETCH;
    endcase

    // Every PC load funnels through here so the alignment check is in one place.
    if (take_target) begin
      if (pc_val_odd) begin
        state_d = FAULT;
        fault_d = 1'b1;
      end else begin
        state_d = FETCH;
        fault_d = 1'b0;
      end
    end
  end

  assign pc_load = take_target;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= FETCH;
      started_q <= 1'b0;
      inst_q    <= '0;
      inst_pc_q <= '0;
      valid_q   <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      started_q <= 1'b1;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      valid_q   <= valid_d;
      fault_q   <= fault_d;
    end
  end

  assign inst_o       = inst_q;
  assign instPc_o     = inst_pc_q;
  assign pcNext_o     = inst_pc_q + WORD'(2);
  assign instValid_o  = valid_q;
  assign alignFault_o = fault_q;

endmodule

// File: tb/tb_xm_fetch_unit.sv
// Self-checking bench for xm_fetch_unit: directed scenarios followed by a
// randomized run scored against a transaction-level next-address model.
module tb_xm_fetch_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        memReq_o;
  logic [15:0] memAdr_o;
  logic        memAck_i;
  logic [15:0] memData_i;
  logic [15:0] inst_o;
  logic [15:0] instPc_o;
  logic [15:0] pcNext_o;
  logic        instValid_o;
  logic        instReady_i;
  logic        redirect_i;
  logic [15:0] redirectPc_i;
  logic        alignFault_o;

  int total    = 0;
  int passed   = 0;
  int waits    = 0;
  int wait_cnt = 0;

  xm_fetch_unit dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .memReq_o     (memReq_o),
    .memAdr_o     (memAdr_o),
    .memAck_i     (memAck_i),
    .memData_i    (memData_i),
    .inst_o       (inst_o),
    .instPc_o     (instPc_o),
    .pcNext_o     (pcNext_o),
    .instValid_o  (instValid_o),
    .instReady_i  (instReady_i),
    .redirect_i   (redirect_i),
    .redirectPc_i (redirectPc_i),
    .alignFault_o (alignFault_o)
  );

  initial forever #5 clk_i = ~clk_i;

  // Instruction memory contents; address 0 holds the reset-vector word.
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (a == 16'h0000) return 16'h2401;
    return (a ^ 16'hA5C3) + {a[7:0], a[15:8]};
  endfunction

  // Memory slave: acks after `waits` wait cycles, decided just after each edge.
  initial begin
    memAck_i  = 1'b0;
    memData_i = 16'hDEAD;
    forever begin
      @(posedge clk_i);
      #1;
      if (memReq_o !== 1'b1) begin
        memAck_i  = 1'b0;
        memData_i = 16'hDEAD;
        wait_cnt  = 0;
      end else if (wait_cnt >= waits) begin
        memAck_i  = 1'b1;
        memData_i = mem_word(memAdr_o);
        wait_cnt  = 0;
      end else begin
        memAck_i  = 1'b0;
        memData_i = 16'hDEAD;
        wait_cnt++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic wait_valid(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      if (instValid_o === 1'b1) begin
        ok = 1'b1;
        return;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1; instReady_i = 1'b0; redirect_i = 1'b0; redirectPc_i = '0; waits = 0;
    tick(); tick();
    rst_i = 1'b0;
    total++; if (memReq_o !== 1'b0) $display("FAIL reset_memReq: got %b want 0", memReq_o); else passed++;
    total++; if ({instValid_o, alignFault_o} !== 2'b00) $display("FAIL reset_flags: got valid=%b fault=%b want 0/0", instValid_o, alignFault_o); else passed++;
    total++; if ({inst_o, instPc_o} !== 32'h0) $display("FAIL reset_inst: got inst=%h pc=%h want 0/0", inst_o, instPc_o); else passed++;
    tick();
    total++; if ({memReq_o, memAdr_o} !== {1'b1, 16'h0000}) $display("FAIL first_req: got req=%b adr=%h want 1/0000", memReq_o, memAdr_o); else passed++;
    tick();
    total++; if (instValid_o !== 1'b1 || inst_o !== 16'h2401) $display("FAIL first_inst: got valid=%b inst=%h want 1/2401", instValid_o, inst_o); else passed++;
    total++; if (instPc_o !== 16'h0000 || pcNext_o !== 16'h0002) $display("FAIL first_pc: got pc=%h next=%h want 0000/0002", instPc_o, pcNext_o); else passed++;
  endtask

  task automatic test_hold_stall();
    int n;
    bit bad;
    bit ok;
    waits = 3;
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      instReady_i = 1'b0;
      tick();
      if ({instValid_o, memReq_o, inst_o} !== {1'b1, 1'b0, 16'h2401}) bad = 1'b1;
    end
    total++; if (bad) $display("FAIL hold_stable: got changing outputs want stable inst 2401 no req"); else passed++;
    instReady_i = 1'b1;
    tick();
    instReady_i = 1'b0;
    total++; if ({instValid_o, memReq_o, memAdr_o} !== {1'b0, 1'b1, 16'h0002}) $display("FAIL consume_req: got valid=%b req=%b adr=%h want 0/1/0002", instValid_o, memReq_o, memAdr_o); else passed++;
    n = 0; bad = 1'b0;
    while (memAck_i !== 1'b1 && n < 10) begin
      if (memReq_o !== 1'b1 || memAdr_o !== 16'h0002) bad = 1'b1;
      tick();
      n++;
    end
    if (memAdr_o !== 16'h0002) bad = 1'b1;
    total++; if (bad || n != 3) $display("FAIL wait_adr_stable: got waits=%0d unstable=%0d want 3/0", n, bad); else passed++;
    wait_valid(5, ok);
    total++; if (!ok || instPc_o !== 16'h0002 || inst_o !== mem_word(16'h0002)) $display("FAIL second_inst: got ok=%0d pc=%h inst=%h want 1/0002/%h", ok, instPc_o, inst_o, mem_word(16'h0002)); else passed++;
  endtask

  task automatic test_redirect_discard();
    bit ok;
    bit adr_bad;
    bit seen_new;
    bit early_valid;
    redirect_i = 1'b1; redirectPc_i = 16'h0010;
    tick();
    redirect_i = 1'b0;
    total++; if ({memReq_o, memAdr_o} !== {1'b1, 16'h0010}) $display("FAIL redir_req10: got req=%b adr=%h want 1/0010", memReq_o, memAdr_o); else passed++;
    tick();
    redirect_i = 1'b1; redirectPc_i = 16'h0100;
    tick();
    redirect_i = 1'b0;
    total++; if ({memReq_o, memAdr_o} !== {1'b1, 16'h0010}) $display("FAIL discard_hold_adr: got req=%b adr=%h want 1/0010", memReq_o, memAdr_o); else passed++;
    adr_bad = 1'b0; seen_new = 1'b0; early_valid = 1'b0; ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (instValid_o === 1'b1) begin
        ok = 1'b1;
        break;
      end
      if (memReq_o === 1'b1) begin
        if (memAdr_o === 16'h0100) seen_new = 1'b1;
        else if (memAdr_o !== 16'h0010 || seen_new) adr_bad = 1'b1;
      end
      tick();
    end
    if (ok && instPc_o === 16'h0010) early_valid = 1'b1;
    total++; if (adr_bad || !seen_new || early_valid) $display("FAIL discard_seq: got adr_bad=%0d seen100=%0d early=%0d want 0/1/0", adr_bad, seen_new, early_valid); else passed++;
    total++; if (!ok || instPc_o !== 16'h0100 || inst_o !== mem_word(16'h0100)) $display("FAIL discard_next: got ok=%0d pc=%h inst=%h want 1/0100/%h", ok, instPc_o, inst_o, mem_word(16'h0100)); else passed++;
  endtask

  task automatic test_redirect_ack_and_hold();
    waits = 0;
    instReady_i = 1'b1;
    tick();
    instReady_i = 1'b0;
    total++; if ({memAck_i, memAdr_o} !== {1'b1, 16'h0102}) $display("FAIL ack_setup: got ack=%b adr=%h want 1/0102", memAck_i, memAdr_o); else passed++;
    redirect_i = 1'b1; redirectPc_i = 16'h0040;
    tick();
    redirect_i = 1'b0;
    total++; if ({instValid_o, memReq_o, memAdr_o} !== {1'b0, 1'b1, 16'h0040}) $display("FAIL redir_on_ack: got valid=%b req=%b adr=%h want 0/1/0040", instValid_o, memReq_o, memAdr_o); else passed++;
    tick();
    total++; if (instValid_o !== 1'b1 || instPc_o !== 16'h0040) $display("FAIL redir_on_ack_inst: got valid=%b pc=%h want 1/0040", instValid_o, instPc_o); else passed++;
    instReady_i = 1'b1; redirect_i = 1'b1; redirectPc_i = 16'h0040;
    tick();
    instReady_i = 1'b0; redirect_i = 1'b0;
    total++; if ({instValid_o, memReq_o, memAdr_o} !== {1'b0, 1'b1, 16'h0040}) $display("FAIL redir_in_hold: got valid=%b req=%b adr=%h want 0/1/0040", instValid_o, memReq_o, memAdr_o); else passed++;
    tick();
    total++; if (instValid_o !== 1'b1 || instPc_o !== 16'h0040 || inst_o !== mem_word(16'h0040)) $display("FAIL redir_in_hold_inst: got valid=%b pc=%h inst=%h want 1/0040/%h", instValid_o, instPc_o, inst_o, mem_word(16'h0040)); else passed++;
  endtask

  task automatic test_align_fault();
    bit bad;
    bit ok;
    redirect_i = 1'b1; redirectPc_i = 16'h0033;
    tick();
    redirect_i = 1'b0;
    total++; if ({alignFault_o, memReq_o, instValid_o} !== 3'b100) $display("FAIL fault_enter: got fault=%b req=%b valid=%b want 1/0/0", alignFault_o, memReq_o, instValid_o); else passed++;
    bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if ({alignFault_o, memReq_o, instValid_o} !== 3'b100) bad = 1'b1;
    end
    total++; if (bad) $display("FAIL fault_stays: got activity during fault want no request"); else passed++;
    redirect_i = 1'b1; redirectPc_i = 16'h0034;
    tick();
    redirect_i = 1'b0;
    total++; if ({alignFault_o, memReq_o, memAdr_o} !== {1'b0, 1'b1, 16'h0034}) $display("FAIL fault_exit: got fault=%b req=%b adr=%h want 0/1/0034", alignFault_o, memReq_o, memAdr_o); else passed++;
    wait_valid(5, ok);
    total++; if (!ok || instPc_o !== 16'h0034 || inst_o !== mem_word(16'h0034)) $display("FAIL fault_exit_inst: got ok=%0d pc=%h inst=%h want 1/0034/%h", ok, instPc_o, inst_o, mem_word(16'h0034)); else passed++;
  endtask

  task automatic test_wrap();
    bit ok;
    redirect_i = 1'b1; redirectPc_i = 16'hFFFE;
    tick();
    redirect_i = 1'b0;
    wait_valid(5, ok);
    total++; if (!ok || instPc_o !== 16'hFFFE || pcNext_o !== 16'h0000) $display("FAIL wrap_pc: got ok=%0d pc=%h next=%h want 1/FFFE/0000", ok, instPc_o, pcNext_o); else passed++;
    waits = 3;
    instReady_i = 1'b1;
    tick();
    instReady_i = 1'b0;
    total++; if ({memReq_o, memAdr_o} !== {1'b1, 16'h0000}) $display("FAIL wrap_req: got req=%b adr=%h want 1/0000", memReq_o, memAdr_o); else passed++;
  endtask

  task automatic test_reset_in_discard();
    bit ok;
    redirect_i = 1'b1; redirectPc_i = 16'h0200;
    tick();
    redirect_i = 1'b0;
    total++; if ({memReq_o, memAdr_o} !== {1'b1, 16'h0000}) $display("FAIL pre_reset_discard: got req=%b adr=%h want 1/0000", memReq_o, memAdr_o); else passed++;
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    total++; if ({memReq_o, instValid_o, alignFault_o, inst_o, instPc_o} !== 35'h0) $display("FAIL discard_reset_out: got req=%b valid=%b fault=%b inst=%h pc=%h want all 0", memReq_o, instValid_o, alignFault_o, inst_o, instPc_o); else passed++;
    tick();
    total++; if ({memReq_o, memAdr_o} !== {1'b1, 16'h0000}) $display("FAIL discard_reset_req: got req=%b adr=%h want 1/0000", memReq_o, memAdr_o); else passed++;
    wait_valid(10, ok);
    total++; if (!ok || instPc_o !== 16'h0000 || inst_o !== 16'h2401) $display("FAIL discard_reset_inst: got ok=%0d pc=%h inst=%h want 1/0000/2401", ok, instPc_o, inst_o); else passed++;
  endtask

  // Model: the next instruction delivered is the latest redirect target, or
  // the previously delivered address + 2 once that one has been consumed.
  task automatic test_random();
    logic [15:0] exp_pc, tgt, prev_inst, prev_ipc, prev_adr;
    bit prev_valid, prev_ready, prev_redir, prev_req, prev_ack, redir, rdy;
    int idle;
    exp_pc = instPc_o;
    prev_valid = 1'b1; prev_ready = 1'b0; prev_redir = 1'b0;
    prev_inst = inst_o; prev_ipc = instPc_o;
    prev_req = 1'b0; prev_ack = 1'b0; prev_adr = '0;
    idle = 0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      if (instValid_o === 1'b1 && !prev_valid) begin
        total++; if (instPc_o !== exp_pc || inst_o !== mem_word(exp_pc) || pcNext_o !== exp_pc + 16'd2) $display("FAIL rnd_deliver: cyc=%0d got pc=%h inst=%h next=%h want %h/%h/%h", cyc, instPc_o, inst_o, pcNext_o, exp_pc, mem_word(exp_pc), exp_pc + 16'd2); else passed++;
      end
      if (prev_valid && (prev_ready || prev_redir)) begin
        total++; if (instValid_o !== 1'b0) $display("FAIL rnd_drop_valid: cyc=%0d got valid=%b want 0", cyc, instValid_o); else passed++;
      end else if (prev_valid) begin
        total++; if (instValid_o !== 1'b1 || inst_o !== prev_inst || instPc_o !== prev_ipc) $display("FAIL rnd_hold: cyc=%0d got valid=%b inst=%h pc=%h want 1/%h/%h", cyc, instValid_o, inst_o, instPc_o, prev_inst, prev_ipc); else passed++;
      end
      if (prev_req && !prev_ack) begin
        total++; if (memReq_o !== 1'b1 || memAdr_o !== prev_adr) $display("FAIL rnd_adr_stable: cyc=%0d got req=%b adr=%h want 1/%h", cyc, memReq_o, memAdr_o, prev_adr); else passed++;
      end
      if (instValid_o === 1'b1) begin
        total++; if (memReq_o !== 1'b0) $display("FAIL rnd_req_in_hold: cyc=%0d got req=%b want 0", cyc, memReq_o); else passed++;
        idle = 0;
      end else begin
        idle++;
      end
      if (idle > 40) begin
        total++;
        $display("FAIL rnd_progress: cyc=%0d got no instruction for %0d cycles want at most 40", cyc, idle);
        break;
      end

      if (memReq_o !== 1'b1) waits = $urandom_range(0, 3);
      redir = ($urandom_range(0, 11) == 0);
      tgt   = 16'($urandom) & 16'hFFFE;
      rdy   = 1'($urandom_range(0, 1));
      if (redir) exp_pc = tgt;
      else if (instValid_o === 1'b1 && rdy) exp_pc = exp_pc + 16'd2;

      prev_valid = (instValid_o === 1'b1);
      prev_ready = rdy;
      prev_redir = redir;
      prev_inst  = inst_o;
      prev_ipc   = instPc_o;
      prev_req   = (memReq_o === 1'b1);
      prev_ack   = (memAck_i === 1'b1);
      prev_adr   = memAdr_o;
      redirect_i   = redir;
      redirectPc_i = tgt;
      instReady_i  = rdy;
      tick();
    end
    redirect_i  = 1'b0;
    instReady_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_hold_stall();
    test_redirect_discard();
    test_redirect_ack_and_hold();
    test_align_fault();
    test_wrap();
    test_reset_in_discard();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
